// File: rtl/apb_pkg.sv
// Shared types and helpers for the multi-slave APB master bridge.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ERR    = 2'd3
    } apb_state_t;

    localparam logic [1:0] RSP_OKAY    = 2'd0;
    localparam logic [1:0] RSP_SLVERR  = 2'd1;
    localparam logic [1:0] RSP_DECERR  = 2'd2;
    localparam logic [1:0] RSP_TIMEOUT = 2'd3;

    // Width of the slave-index field; at least one bit even for a single slave.
    function automatic int unsigned idx_w(input int unsigned nslv);
        return (nslv <= 2) ? 1 : $clog2(nslv);
    endfunction

    function automatic logic is_err(input logic [1:0] code);
        return code != RSP_OKAY;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Address decoder: slave index, one-hot select and out-of-range flag.
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned NSLV      = 4,
    parameter int unsigned SLV_SHIFT = 12,
    localparam int unsigned IDX_W    = idx_w(NSLV)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  idx,
    output logic [NSLV-1:0]   sel,
    output logic              dec_err
);

    logic unused_addr;
    assign unused_addr = ^addr;

    always_comb begin
        idx     = addr[SLV_SHIFT +: IDX_W];
        dec_err = {1'b0, idx} >= (IDX_W+1)'(NSLV);
        sel     = '0;
        for (int i = 0; i < int'(NSLV); i++) begin
            sel[i] = !dec_err && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/apb_master_mux.sv
// APB master bridge: valid/ready command port to NSLV decoded APB slaves,
// with wait states, PSLVERR, decode errors and an ACCESS timeout.
module apb_master_mux
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NSLV      = 4,
    parameter int unsigned SLV_SHIFT = 12,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                   pclk,
    input  logic                   preset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic [NSLV-1:0]        psel,
    output logic                   penable,
    output logic                   pwrite,
    output logic [ADDR_W-1:0]      paddr,
    output logic [DATA_W-1:0]      pwdata,
    input  logic [NSLV*DATA_W-1:0] prdata,
    input  logic [NSLV-1:0]        pready,
    input  logic [NSLV-1:0]        pslverr
);

    localparam int unsigned IDX_W = idx_w(NSLV);
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    apb_state_t        state;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  dec_idx;
    logic [NSLV-1:0]   dec_sel;
    logic              dec_err;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] sel_rdata;
    logic              sel_ready;
    logic              sel_err;
    logic [1:0]        slv_code;

    apb_addr_decode #(
        .ADDR_W    (ADDR_W),
        .NSLV      (NSLV),
        .SLV_SHIFT (SLV_SHIFT)
    ) u_decode (
        .addr    (req_addr),
        .idx     (dec_idx),
        .sel     (dec_sel),
        .dec_err (dec_err)
    );

    assign req_ready = (state == IDLE) && !preset;

    // Response mux keyed on the registered index so unselected slaves are ignored.
    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        for (int i = 0; i < int'(NSLV); i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_rdata = prdata[i*DATA_W +: DATA_W];
                sel_ready = pready[i];
                sel_err   = pslverr[i];
            end
        end
        slv_code = sel_err ? RSP_SLVERR : RSP_OKAY;
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= IDLE;
            idx_q     <= '0;
            cnt       <= '0;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (dec_err) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= is_err(RSP_DECERR);
                            rsp_rdata <= '0;
                            state     <= ERR;
                        end else begin
                            paddr  <= req_addr;
                            pwdata <= req_wdata;
                            pwrite <= req_write;
                            idx_q  <= dec_idx;
                            psel   <= dec_sel;
                            cnt    <= '0;
                            state  <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (sel_ready) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= pwrite ? '0 : sel_rdata;
                        rsp_err   <= is_err(slv_code);
                        psel      <= '0;
                        penable   <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= is_err(RSP_TIMEOUT);
                        psel      <= '0;
                        penable   <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ERR: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_psel_onehot: assert property (@(posedge pclk) disable iff (preset) $onehot0(psel));
    a_penable_sel: assert property (@(posedge pclk) disable iff (preset) penable |-> (psel != '0));
    a_accept_idle: assert property (@(posedge pclk) disable iff (preset)
                                    (req_valid && req_ready) |-> (state == IDLE));

endmodule

// File: doc/apb_master_mux.md
Name: apb_master_mux

Overview:
Parametrised APB master bridge, successor to the single-slave bridge. It accepts read/write requests on a simple valid/ready command port and runs each request as an APB SETUP/ACCESS transfer. Address decoding drives one of NSLV one-hot PSEL lines and muxes the slave responses. Adds wait-state handling, PSLVERR propagation, decode-error responses and an access timeout.

Parameters:
ADDR_W, 16, address width (paddr, req_addr)
DATA_W, 16, data width (pwdata, prdata, rdata)
NSLV, 4, number of slaves, 1..16
SLV_SHIFT, 12, LSB of the slave-index field in the address
TIMEOUT, 16, maximum ACCESS cycles without pready; 0 disables the timeout

Ports:
pclk  in  1  clock; all logic on rising edge
preset  in  1  synchronous reset, active-high
req_valid  in  1  command valid
req_ready  out  1  command accepted when req_valid && req_ready
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data; 0 for writes and errors
rsp_err  out  1  PSLVERR, decode error or timeout
psel  out  NSLV  one-hot slave select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata  in  NSLV*DATA_W  flattened read data; slave i at [i*DATA_W +: DATA_W]
pready  in  NSLV  per-slave ready
pslverr  in  NSLV  per-slave error

Behaviour:
- Reset: sync, active-high. State = IDLE. psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0. Reset wins over any other event, including a transfer in progress; psel and penable drop on the next edge.
- Index idx = req_addr[SLV_SHIFT +: IDX_W], where IDX_W = max(1, clog2(NSLV)). A request with idx >= NSLV is a decode error.
- req_ready = (state == IDLE) && !preset. It is combinational from state only and does not depend on req_valid.
- State IDLE:
  - On accept with a valid idx: register paddr, pwdata, pwrite and idx; set psel[idx]=1; go to SETUP.
  - On accept with an invalid idx: no APB activity; go to ERR.
- State SETUP: psel held, penable=0. Go to ACCESS next cycle unconditionally.
- State ACCESS: penable=1.
  - If pready[idx]: latch rsp_rdata = write ? 0 : prdata slice idx, and rsp_err = pslverr[idx]. Pulse rsp_valid, drop psel and penable, go to IDLE.
  - Else increment the counter. When counter == TIMEOUT-1 with TIMEOUT != 0: rsp_err=1, rsp_rdata=0, pulse rsp_valid, drop psel and penable, go to IDLE.
  - Pready of unselected slaves is ignored.
- State ERR: rsp_valid=1, rsp_err=1, rsp_rdata=0 for one cycle, then go to IDLE.
- Timing:
  - rsp_valid is high for exactly one cycle, the first cycle back in IDLE.
  - req_ready is high in that same cycle, so back-to-back requests are possible.
  - Minimum pitch is 3 cycles per transfer: accept, SETUP, ACCESS.
- paddr, pwdata and pwrite are stable from SETUP through the end of ACCESS. They hold their last value in IDLE.
- The timeout counter clears on entry to SETUP and is held at 0 outside ACCESS.
- Assertions:
  - psel is one-hot or zero.
  - penable implies psel != 0.
  - No request is accepted outside IDLE.

Decomposition:
- Package apb_pkg holds:
  - state enum {IDLE, SETUP, ACCESS, ERR}, 2 bits
  - response-code constants
  - IDX_W helper function
- Sub-module apb_addr_decode (combinational): address -> idx, one-hot select, decode-error flag. The read-data/ready/error mux stays in the top.

Test Plan:
- Write, no wait: preset high 2 cycles, then req write addr 0x1004, wdata 0xBEEF; slave 1 pready=1 -> psel=4'b0010; SETUP 1 cycle, ACCESS 1 cycle; pwdata=0xBEEF; rsp_valid 3 cycles after accept with rsp_err=0.
- Read with 3 wait states: addr 0x2010, slave 2 pready low for 3 ACCESS cycles, prdata=0x1234 -> penable high 4 cycles; rsp_rdata=0x1234, rsp_err=0.
- PSLVERR: read to slave 3, pready=1, pslverr=1 -> rsp_err=1, transfer completes normally.
- Decode error: NSLV=3, addr 0x3000 -> psel never asserted; rsp_valid with rsp_err=1 one cycle after accept.
- Timeout: TIMEOUT=16, slave 0 pready stuck low -> ACCESS lasts 16 cycles, then psel/penable drop; rsp_err=1, rsp_rdata=0.
- Reset mid-ACCESS and back-to-back:
  - Assert preset during ACCESS -> next edge psel=0, penable=0, no rsp_valid, state IDLE.
  - Hold req_valid high for 2 writes -> accepts exactly 3 cycles apart.
